// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Mini-SRC control unit: fetch T0-T2, execute T3-T6
module control_sequencer #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int COUNT_W     = 16
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               run,
    input  logic               mem_ready,
    input  logic [31:0]        IR,
    output logic [15:0]        Rin,
    output logic [15:0]        Rout,
    output logic               PCout,
    output logic               PCin,
    output logic               IncPC,
    output logic               MARin,
    output logic               MDRin,
    output logic               MDRout,
    output logic               Read,
    output logic               IRin,
    output logic               Yin,
    output logic               Zin,
    output logic               Zlowout,
    output logic               Zhighout,
    output logic               LOin,
    output logic               HIin,
    output logic [4:0]         ALU_Control,
    output logic               done,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count,
    output logic [3:0]         state
);

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       is_bin;
    logic       is_md;
    logic       is_un;
    logic       unused_ir;

    // IR is decoded live; the datapath keeps it stable from T2 onward
    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    assign is_bin = (opcode <= 5'd8);
    assign is_md  = (opcode == 5'd15) || (opcode == 5'd16);
    assign is_un  = (opcode == 5'd17) || (opcode == 5'd18);

    assign state = cur_state;

    // state register; clear aborts any instruction in flight
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // sticky flag raised when T2 sees an opcode outside the supported classes
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            illegal <= 1'b0;
        end else if (cur_state == T2 && !(is_bin || is_md || is_un)) begin
            illegal <= 1'b1;
        end
    end

    // retired-instruction counter, bumped on leaving the done state, wraps naturally
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            instr_count <= '0;
        end else if (done) begin
            instr_count <= instr_count + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    // next-state sequencing; illegal opcodes skip execution entirely
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE: nxt_state = run ? T0 : IDLE;
            T0:   nxt_state = T1;
            T1:   nxt_state = (mem_ready || !MEM_WAIT_EN) ? T2 : T1;
            T2: begin
                if (is_bin || is_md) begin
                    nxt_state = T3;
                end else if (is_un) begin
                    nxt_state = T4;
                end else begin
                    nxt_state = run ? T0 : IDLE;
                end
            end
            T3:   nxt_state = T4;
            T4:   nxt_state = T5;
            T5:   nxt_state = is_md ? T6 : (run ? T0 : IDLE);
            T6:   nxt_state = run ? T0 : IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // control decode from present state and IR; everything idles low
    always_comb begin
        Rin         = 16'd0;
        Rout        = 16'd0;
        PCout       = 1'b0;
        PCin        = 1'b0;
        IncPC       = 1'b0;
        MARin       = 1'b0;
        MDRin       = 1'b0;
        MDRout      = 1'b0;
        Read        = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Zin         = 1'b0;
        Zlowout     = 1'b0;
        Zhighout    = 1'b0;
        LOin        = 1'b0;
        HIin        = 1'b0;
        ALU_Control = 5'd0;
        done        = 1'b0;
        case (cur_state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                Yin  = 1'b1;
                Rout = is_md ? (16'd1 << ra) : (16'd1 << rb);
            end
            T4: begin
                Zin         = 1'b1;
                ALU_Control = opcode;
                Rout        = is_bin ? (16'd1 << rc) : (16'd1 << rb);
            end
            T5: begin
                Zlowout = 1'b1;
                if (is_md) begin
                    LOin = 1'b1;
                end else begin
                    Rin  = 16'd1 << ra;
                    done = 1'b1;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the Mini-SRC datapath's control inputs, sitting directly upstream of the datapath.
- Replaces the hand-written per-state control assignments with an FSM that sequences instruction fetch (T0–T2) and execution (T3–T6).
- Decodes register-to-register ALU, unary, and mul/div instructions from the datapath's IR.
- Supports a memory-ready wait state in T1.

Parameters:
- MEM_WAIT_EN, 1: 1 = T1 holds until mem_ready; 0 = T1 always lasts one cycle.
- COUNT_W, 16: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous active-high reset.
- run  in  1  level; when high, the sequencer fetches and executes instructions.
- mem_ready  in  1  memory data valid during T1.
- IR  in  32  datapath IR contents: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- Rin  out  16  one-hot general-register load enables, R0..R15.
- Rout  out  16  one-hot general-register bus drive enables.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin, Zlowout, Zhighout, LOin, HIin  out  1 each  datapath controls.
- ALU_Control  out  5  ALU operation select.
- done  out  1  one-cycle pulse in the final state of each instruction.
- illegal  out  1  sticky flag for an unsupported opcode.
- instr_count  out  COUNT_W  count of retired instructions.
- state  out  4  present state, for debug.

Behaviour:
- States and encodings:
  - IDLE = 0
  - T0 = 1
  - T1 = 2
  - T2 = 3
  - T3 = 4
  - T4 = 5
  - T5 = 6
  - T6 = 7
- State register and reset:
  - The state register is the only state element besides illegal and instr_count.
  - clear asserted forces IDLE, illegal = 0 and instr_count = 0 immediately, including mid-instruction.
  - All control outputs are a combinational decode of state and IR, so every output is 0 in IDLE and during reset.
- Transitions:
  - IDLE -> T0 when run = 1.
  - T0 -> T1.
  - T1 -> T2 when mem_ready = 1 or MEM_WAIT_EN = 0; otherwise stay in T1.
  - T2 -> T3 for binary and mul/div opcodes; T2 -> T4 for unary opcodes; T2 -> T0 or IDLE (per run) for illegal opcodes.
  - T3 -> T4 -> T5.
  - T5 -> T6 for mul/div; otherwise T5 -> T0 if run = 1, else IDLE.
  - T6 -> T0 if run = 1, else IDLE.
- Per-state outputs (all other outputs 0):
  - T0: PCout, MARin, IncPC, Zin; ALU_Control = 00000.
  - T1: Zlowout, PCin, Read, MDRin, held on every wait cycle. Repeating PCin is idempotent because Z is not written in T1.
  - T2: MDRout, IRin.
  - T3 (binary): Rout[Rb], Yin.
  - T3 (mul/div): Rout[Ra], Yin.
  - T4 (binary): Rout[Rc], Zin, ALU_Control = opcode.
  - T4 (unary): Rout[Rb], Zin, ALU_Control = opcode.
  - T4 (mul/div): Rout[Rb], Zin, ALU_Control = opcode.
  - T5 (non-mul/div): Zlowout, Rin[Ra], done.
  - T5 (mul/div): Zlowout, LOin.
  - T6: Zhighout, HIin, done.
- Opcode classes:
  - Binary: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 shr, 00101 shra, 00110 shl, 00111 ror, 01000 rol.
  - Mul/div: 01111 mul, 10000 div.
  - Unary: 10001 neg, 10010 not.
  - Every other opcode is illegal.
- Illegal opcode: in T2, if the IR input already holds an illegal opcode, set illegal = 1. No Rin/HIin/LOin is ever asserted for it, and instr_count does not increment.
- Counter: instr_count increments on the clock edge leaving a state with done = 1, and wraps from all-ones to 0.
- IR decode in T3–T6 uses the IR input live; the datapath holds IR stable after T2.
- Rin and Rout always have at most one bit set.
- run dropping mid-instruction: the current instruction completes, then the sequencer goes to IDLE.

Test Plan:
- Reset, run = 0, 3 cycles -> state = 0; all controls and Rin/Rout = 0; instr_count = 0; illegal = 0.
- run = 1, mem_ready = 1, IR = 0x2B820000 (shra R7, R0, R4) -> T3: Rout = 0x0001, Yin. T4: Rout = 0x0010, ALU_Control = 00101, Zin. T5: Zlowout, Rin = 0x0080, done. instr_count = 1.
- mem_ready low for 3 cycles in T1 -> T1 lasts 4 cycles with Read, MDRin, PCin held; T2 follows the cycle mem_ready = 1. With MEM_WAIT_EN = 0, T1 lasts 1 cycle.
- IR = 0x79880000 (mul R3, R1) -> T3: Rout = 0x0008. T4: Rout = 0x0002, ALU_Control = 01111. T5: Zlowout, LOin. T6: Zhighout, HIin, done. Rin = 0 throughout.
- IR = 0x91280000 (not R2, R5) -> T2 -> T4 directly: Rout = 0x0020, ALU_Control = 10010. T5: Rin = 0x0004, done.
- IR = 0xF8000000 -> illegal = 1 after T2, next state is T0, instr_count unchanged, no register write. Assert clear during T4 of a following add -> state = 0, outputs 0, illegal = 0 immediately.
